// File: rtl/csr_trap_if.sv
// rtl/csr_trap_if.sv - WB-to-CSR commit interface bundle
interface csr_trap_if;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_rvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    modport master (
        output csr_re, csr_we, csr_num, csr_wmask, csr_wvalue,
        output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
        output hw_int_in, ipi_int_in,
        input  csr_rvalue, ex_entry, ertn_entry, has_int
    );

    modport slave (
        input  csr_re, csr_we, csr_num, csr_wmask, csr_wvalue,
        input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
        input  hw_int_in, ipi_int_in,
        output csr_rvalue, ex_entry, ertn_entry, has_int
    );
endinterface

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - exception/interrupt CSR file with stable timer
module csr_trap_unit #(
    parameter logic [31:0] TID_RESET    = 32'h0,
    parameter logic [31:0] EENTRY_RESET = 32'h1C00_8000
) (
    input logic       clk,
    input logic       reset,
    csr_trap_if.slave bus
);
    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_BADV   = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00C;
    localparam logic [13:0] A_SAVE0  = 14'h030;
    localparam logic [13:0] A_SAVE1  = 14'h031;
    localparam logic [13:0] A_SAVE2  = 14'h032;
    localparam logic [13:0] A_SAVE3  = 14'h033;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;
    localparam logic [5:0]  ECODE_ADE = 6'h08;
    localparam logic [5:0]  ECODE_ALE = 6'h09;

    logic [31:0] crmd, prmd, ecfg, estat, era, badv, eentry, tid, tcfg, tval;
    logic [31:0] save [4];
    logic        timer_en;
    logic        wr_en;
    logic        timer_fire;
    logic [31:0] tcfg_new;
    logic [31:0] rdata;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] fld,
                                          input logic [31:0] wmask, input logic [31:0] wvalue);
        logic [31:0] m;
        m = wmask & fld;
        return (old & ~m) | (wvalue & m);
    endfunction

    // A write colliding with an exception commit is discarded outright.
    assign wr_en      = bus.csr_we & ~bus.wb_ex;
    assign timer_fire = timer_en & (tval == 32'h0);
    assign tcfg_new   = merge(tcfg, 32'hFFFF_FFFF, bus.csr_wmask, bus.csr_wvalue);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crmd     <= 32'h0000_0008;
            prmd     <= 32'h0;
            ecfg     <= 32'h0;
            estat    <= 32'h0;
            era      <= 32'h0;
            badv     <= 32'h0;
            eentry   <= EENTRY_RESET & 32'hFFFF_FFC0;
            tid      <= TID_RESET;
            tcfg     <= 32'h0;
            tval     <= 32'hFFFF_FFFF;
            timer_en <= 1'b0;
            for (int i = 0; i < 4; i++) save[i] <= 32'h0;
        end else begin
            if (wr_en) begin
                case (bus.csr_num)
                    A_CRMD:   crmd   <= merge(crmd, 32'h0000_01FF, bus.csr_wmask, bus.csr_wvalue);
                    A_PRMD:   prmd   <= merge(prmd, 32'h0000_0007, bus.csr_wmask, bus.csr_wvalue);
                    A_ECFG:   ecfg   <= merge(ecfg, 32'h0000_1BFF, bus.csr_wmask, bus.csr_wvalue);
                    A_ESTAT:  estat  <= merge(estat, 32'h0000_0003, bus.csr_wmask, bus.csr_wvalue);
                    A_ERA:    era    <= merge(era, 32'hFFFF_FFFF, bus.csr_wmask, bus.csr_wvalue);
                    A_BADV:   badv   <= merge(badv, 32'hFFFF_FFFF, bus.csr_wmask, bus.csr_wvalue);
                    A_EENTRY: eentry <= merge(eentry, 32'hFFFF_FFC0, bus.csr_wmask, bus.csr_wvalue);
                    A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                        save[bus.csr_num[1:0]] <= merge(save[bus.csr_num[1:0]], 32'hFFFF_FFFF,
                                                        bus.csr_wmask, bus.csr_wvalue);
                    A_TID:    tid    <= merge(tid, 32'hFFFF_FFFF, bus.csr_wmask, bus.csr_wvalue);
                    A_TCFG:   tcfg   <= tcfg_new;
                    A_TICLR:  if (bus.csr_wmask[0] & bus.csr_wvalue[0]) estat[11] <= 1'b0;
                    default: ;
                endcase
            end

            if (bus.wb_ex) begin
                prmd[2:0]    <= crmd[2:0];
                crmd[2:0]    <= 3'b000;
                era          <= bus.wb_pc;
                estat[21:16] <= bus.wb_ecode;
                estat[30:22] <= bus.wb_esubcode;
                if (bus.wb_ecode == ECODE_ADE && bus.wb_esubcode == 9'd0)
                    badv <= bus.wb_pc;
                else if ((bus.wb_ecode == ECODE_ADE && bus.wb_esubcode == 9'd1) || bus.wb_ecode == ECODE_ALE)
                    badv <= bus.wb_vaddr;
            end else if (bus.ertn_flush) begin
                crmd[2:0] <= prmd[2:0];
            end

            estat[9:2] <= bus.hw_int_in;
            estat[12]  <= bus.ipi_int_in;

            if (wr_en && bus.csr_num == A_TCFG) begin
                tval     <= {tcfg_new[31:2], 2'b00};
                timer_en <= tcfg_new[0];
            end else if (timer_en) begin
                if (tval != 32'h0) begin
                    tval <= tval - 32'd1;
                end else if (tcfg[1]) begin
                    tval <= {tcfg[31:2], 2'b00};
                end else begin
                    tval     <= 32'hFFFF_FFFF;
                    timer_en <= 1'b0;
                end
            end
            // Placed after the TICLR clear so a simultaneous fire keeps IS[11] set.
            if (timer_fire) estat[11] <= 1'b1;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (bus.csr_num)
            A_CRMD:   rdata = crmd;
            A_PRMD:   rdata = prmd;
            A_ECFG:   rdata = ecfg;
            A_ESTAT:  rdata = estat;
            A_ERA:    rdata = era;
            A_BADV:   rdata = badv;
            A_EENTRY: rdata = eentry;
            A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: rdata = save[bus.csr_num[1:0]];
            A_TID:    rdata = tid;
            A_TCFG:   rdata = tcfg;
            A_TVAL:   rdata = tval;
            default:  rdata = 32'h0;
        endcase
    end

    assign bus.csr_rvalue = bus.csr_re ? rdata : 32'h0;
    assign bus.ex_entry   = {eentry[31:6], 6'b000000};
    assign bus.ertn_entry = era;
    assign bus.has_int    = (|(estat[12:0] & ecfg[12:0])) & crmd[2];
endmodule
